multi_tone_generator: RTL and testbench
=======================================

# multi_tone_generator

Parametrised multi-channel square-wave tone generator for the 125 MHz audio path. Each channel produces a square wave from a programmable half-period, with per-channel enable and volume. All channels are summed into a single 1-bit PWM output that drives the speaker pin. Channel settings are loaded through a valid/ready configuration port, and period changes are glitch-free.

## Interface
Parameters:
- NUM_CH, 2: number of tone channels (1..8).
- PERIOD_W, 24: half-period width in clock cycles.
- VOL_W, 4: per-channel volume width.

Ports:
- clk  in  1  125 MHz clock; sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- output_enable  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration write accept.
- cfg_ch  in  $clog2(NUM_CH) or 1  target channel.
- cfg_half_period  in  PERIOD_W  half-period in cycles; 0 = channel silent.
- cfg_volume  in  VOL_W  channel volume; 0 = mute.
- square_wave_out  out  NUM_CH  raw per-channel tone state, registered.
- mix_out  out  1  PWM of the summed active volumes, registered.

## Operation
- Write handshake: a write is taken on a cycle with cfg_valid && cfg_ready. cfg_ready is 1 in every cycle except during reset.
- Writes with cfg_ch >= NUM_CH are accepted and have no effect.
- Volume takes effect on the cycle after the write.
- Half-period on an idle channel: if the channel's output_enable is 0 or its current half-period is 0, the new value loads directly. The channel's counter clears and its state is set to 0.
- Half-period on a running channel: the new value goes into a pending register and a pending flag is set. The next toggle boundary copies pending into current and clears the flag.
- A second write before that boundary overwrites pending; the last write wins.
- Channel counter, when enabled and half-period P is not 0:
  - counts 0..P-1;
  - at P-1 it toggles state and clears to 0, and the pending value (if any) is applied at the same time.
- P = 1 toggles every cycle.
- output_enable low: counter held at 0 and state forced to 0; the pending value is kept.
- output_enable rising: the counter starts at 0 with state 0, and the first toggle comes P cycles later.
- Mix path:
  - level = sum over all channels of (state_c ? volume_c : 0), width VOL_W + $clog2(NUM_CH+1);
  - a free-running carrier counter of the same width wraps to 0 at its all-ones value;
  - mix_out = (carrier < level).
- All volumes 0 gives mix_out constant 0.
- The maximum level, all-ones, gives mix_out 0 for exactly one carrier cycle out of 2^width.

## Timing
- Reset values: every counter, state, current and pending half-period, pending flag and volume is 0. carrier = 0, square_wave_out = 0, mix_out = 0, cfg_ready = 0.
- cfg_ready rises on the first clk edge after rst_n deasserts.
- Reset asserted mid-operation clears everything at once, with no clock needed. Configuration must be rewritten after reset.
- square_wave_out toggles on the clk edge where the counter equals P-1, with no extra pipeline stage.
- mix_out is one register stage after square_wave_out and the volume registers. Latency from a tone toggle to its effect on mix_out is 1 cycle.
- A write and a boundary in the same cycle on the same channel:
  - the boundary uses the old pending value;
  - the write then becomes the new pending value, and the flag stays set.
- A write and an output_enable fall in the same cycle: the write goes to pending.

## Structure
- Shared package tone_pkg:
  - CLOCK_FREQUENCY = 125_000_000;
  - default PERIOD_W and VOL_W;
  - a constant function half_period(freq_hz) = CLOCK_FREQUENCY / (2*freq_hz), used by the benches and the top level.
- Sub-module tone_channel, instantiated NUM_CH times with a generate loop. It holds one channel's counter, state, current and pending half-period, pending flag and volume.
- The top level holds the config decode, the adder tree, the carrier counter and the mix_out register.

## Test plan
- Reset release: check all outputs stay 0 and cfg_ready = 1 one cycle after rst_n rises. Then write ch0 with P=4, vol=15 and enable it: square_wave_out[0] toggles every 4 cycles (period 8).
- Glitch-free retune: ch0 running at P=10. Write P=3 at counter = 2. Required:
  - the current half-cycle completes at 10 cycles;
  - every later half-cycle is 3 cycles.
- Back-to-back writes: ch1 running at P=100. Write P=20 and then P=50 before the boundary. Only P=50 is applied, at the boundary.
- Enable gating: drop output_enable[0] mid-half-cycle. Output goes to 0 on the next edge. Re-enabling with P=5 gives the first toggle 5 cycles after the rise.
- Mix PWM with NUM_CH=2, VOL_W=4 (width 6):
  - both channels high, vol 8 and 4: mix_out is high for 12 of every 64 cycles;
  - all volumes 0: mix_out is always 0.
- Edge cases:
  - P=0 write: the channel stays at 0;
  - P=1: the channel toggles every cycle;
  - a write with cfg_ch = NUM_CH: no channel changes;
  - rst_n asserted mid-tone: all outputs 0 immediately, with no clock edge.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the tone generator family: clock rate, default widths
// and the frequency-to-half-period conversion used when programming channels.
package tone_pkg;

   localparam int unsigned CLOCK_FREQUENCY = 125_000_000;
   localparam int          DEF_PERIOD_W    = 24;
   localparam int          DEF_VOL_W       = 4;

   function automatic int unsigned half_period(input int unsigned freq_hz);
      return CLOCK_FREQUENCY / (2 * freq_hz);
   endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone channel: half-period counter, tone state, current and
// pending half-period with a glitch-free handover at the toggle boundary.
module tone_channel
   import tone_pkg::*;
#(
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int VOL_W    = DEF_VOL_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                wr_i,
   input  logic [PERIOD_W-1:0] half_period_i,
   input  logic [VOL_W-1:0]    volume_i,
   output logic                state_o,
   output logic [VOL_W-1:0]    volume_o
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] cur_q, cur_d;
   logic [PERIOD_W-1:0] pend_q, pend_d;
   logic                state_q, state_d;
   logic                pflag_q, pflag_d;
   logic [VOL_W-1:0]    vol_q, vol_d;
   logic                en_q;
   logic                idle;
   logic                silent;
   logic                boundary;

   // A channel that was enabled last cycle still counts as running, so a write
   // landing on the enable-fall cycle is deferred to pending.
   assign idle     = !(en_i || en_q) || (cur_q == '0);
   assign silent   = !en_i || (cur_q == '0);
   assign boundary = !silent && (cnt_q == cur_q - PERIOD_W'(1));

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      cur_d   = cur_q;
      pend_d  = pend_q;
      pflag_d = pflag_q;
      vol_d   = vol_q;

      if (silent) begin
         cnt_d   = '0;
         state_d = 1'b0;
      end else if (boundary) begin
         cnt_d   = '0;
         state_d = !state_q;
         if (pflag_q) begin
            cur_d   = pend_q;
            pflag_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end

      // A write on a boundary cycle overrides the flag clear: the boundary
      // consumed the old pending value, the new one waits for the next.
      if (wr_i) begin
         vol_d = volume_i;
         if (idle) begin
            cur_d   = half_period_i;
            cnt_d   = '0;
            state_d = 1'b0;
            pflag_d = 1'b0;
         end else begin
            pend_d  = half_period_i;
            pflag_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         cur_q   <= '0;
         pend_q  <= '0;
         state_q <= 1'b0;
         pflag_q <= 1'b0;
         vol_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         pflag_q <= pflag_d;
         vol_q   <= vol_d;
         en_q    <= en_i;
      end
   end

   assign state_o  = state_q;
   assign volume_o = vol_q;

endmodule

// File: rtl/multi_tone_generator.sv
// Multi-channel square-wave generator: config decode, per-channel tone cores,
// volume mixing and a single-bit PWM output for the speaker pin.
module multi_tone_generator
   import tone_pkg::*;
#(
   parameter  int NUM_CH   = 2,
   parameter  int PERIOD_W = DEF_PERIOD_W,
   parameter  int VOL_W    = DEF_VOL_W,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W    = VOL_W + $clog2(NUM_CH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   output_enable,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [PERIOD_W-1:0] cfg_half_period,
   input  logic [VOL_W-1:0]    cfg_volume,
   output logic [NUM_CH-1:0]   square_wave_out,
   output logic                mix_out
);

   logic                ready_q;
   logic                cfg_take;
   logic [NUM_CH-1:0]   state;
   logic [VOL_W-1:0]    vol [NUM_CH];
   logic [LVL_W-1:0]    level;
   logic [LVL_W-1:0]    carrier_q, carrier_d;
   logic                mix_q, mix_d;

   assign cfg_take = cfg_valid && ready_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic wr;
      // Out-of-range channel numbers simply match no instance.
      assign wr = cfg_take && (32'(cfg_ch) == c);

      tone_channel #(
         .PERIOD_W (PERIOD_W),
         .VOL_W    (VOL_W)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .en_i          (output_enable[c]),
         .wr_i          (wr),
         .half_period_i (cfg_half_period),
         .volume_i      (cfg_volume),
         .state_o       (state[c]),
         .volume_o      (vol[c])
      );
   end

   always_comb begin
      level = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (state[c]) level = level + LVL_W'(vol[c]);
      end
   end

   // Carrier wraps naturally at all-ones; full-scale level leaves one low slot.
   assign carrier_d = carrier_q + LVL_W'(1);
   assign mix_d     = (carrier_q < level);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b0;
         carrier_q <= '0;
         mix_q     <= 1'b0;
      end else begin
         ready_q   <= 1'b1;
         carrier_q <= carrier_d;
         mix_q     <= mix_d;
      end
   end

   assign cfg_ready       = ready_q;
   assign square_wave_out = state;
   assign mix_out         = mix_q;

endmodule

// File: tb/tb_multi_tone_generator.sv
// Directed and randomized bench for multi_tone_generator with three channels,
// checked each cycle against a countdown-based behavioural model.
module tb_multi_tone_generator;
   import tone_pkg::*;

   localparam int NCH      = 3;
   localparam int PERIOD_W = 24;
   localparam int VOL_W    = 4;
   localparam int CH_W     = 2;
   localparam int CAR_MOD  = 64;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NCH-1:0]      oe = '0;
   logic                cfg_valid = 1'b0;
   logic                cfg_ready;
   logic [CH_W-1:0]     cfg_ch = '0;
   logic [PERIOD_W-1:0] cfg_hp = '0;
   logic [VOL_W-1:0]    cfg_vol = '0;
   logic [NCH-1:0]      square_wave_out;
   logic                mix_out;

   int ncmp = 0;
   int nfail = 0;

   // model: cycles left in the current half, plus the programmed settings
   int m_left[NCH];
   int m_cur[NCH];
   int m_pend[NCH];
   bit m_pf[NCH];
   bit m_st[NCH];
   bit m_enp[NCH];
   int m_vol[NCH];
   bit m_mix;
   bit m_rdy;
   int m_car;

   multi_tone_generator #(
      .NUM_CH   (NCH),
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .output_enable   (oe),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_ch          (cfg_ch),
      .cfg_half_period (cfg_hp),
      .cfg_volume      (cfg_vol),
      .square_wave_out (square_wave_out),
      .mix_out         (mix_out)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_left[c] = 0; m_cur[c] = 0; m_pend[c] = 0; m_pf[c] = 0;
         m_st[c] = 0; m_enp[c] = 0; m_vol[c] = 0;
      end
      m_mix = 0; m_rdy = 0; m_car = 0;
   endtask

   task automatic model_edge();
      int  lvl;
      bit  take;
      bit  idle;
      lvl = 0;
      for (int c = 0; c < NCH; c++) if (m_st[c]) lvl += m_vol[c];
      m_mix = (m_car < lvl);
      m_car = (m_car + 1) % CAR_MOD;
      take  = cfg_valid && m_rdy;
      for (int c = 0; c < NCH; c++) begin
         idle = !(oe[c] || m_enp[c]) || (m_cur[c] == 0);
         if (!oe[c] || m_cur[c] == 0) begin
            m_st[c]   = 0;
            m_left[c] = m_cur[c];
         end else if (m_left[c] == 1) begin
            m_st[c] = !m_st[c];
            if (m_pf[c]) begin
               m_cur[c] = m_pend[c];
               m_pf[c]  = 0;
            end
            m_left[c] = m_cur[c];
         end else begin
            m_left[c]--;
         end
         if (take && int'(cfg_ch) == c) begin
            m_vol[c] = int'(cfg_vol);
            if (idle) begin
               m_cur[c]  = int'(cfg_hp);
               m_left[c] = int'(cfg_hp);
               m_st[c]   = 0;
               m_pf[c]   = 0;
            end else begin
               m_pend[c] = int'(cfg_hp);
               m_pf[c]   = 1;
            end
         end
         m_enp[c] = oe[c];
      end
      m_rdy = 1;
   endtask

   task automatic tick();
      logic [31:0] exp_swo;
      model_edge();
      @(posedge clk);
      #1;
      exp_swo = '0;
      for (int c = 0; c < NCH; c++) exp_swo[c] = m_st[c];
      check("square_wave_out", 32'(square_wave_out), exp_swo);
      check("mix_out", 32'(mix_out), 32'(m_mix));
      check("cfg_ready", 32'(cfg_ready), 32'(m_rdy));
   endtask

   task automatic wr(input int ch, input int p, input int v);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_hp    = PERIOD_W'(p);
      cfg_vol   = VOL_W'(v);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_toggle(input int c, input int budget, output int n);
      logic prev;
      prev = square_wave_out[c];
      n = 0;
      do begin
         tick();
         n++;
      end while (square_wave_out[c] === prev && n < budget);
      if (square_wave_out[c] === prev) begin
         ncmp++;
         nfail++;
         $error("FAIL toggle_timeout ch%0d: no toggle within %0d cycles", c, budget);
      end
   endtask

   initial begin
      int n;
      int cnt;
      logic prev;

      model_reset();
      #2;
      check("reset_swo", 32'(square_wave_out), 0);
      check("reset_mix", 32'(mix_out), 0);
      check("reset_ready", 32'(cfg_ready), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("ready_after_release", 32'(cfg_ready), 1);

      // basic tone, P=4
      oe[0] = 1'b1;
      wr(0, 4, 15);
      wait_toggle(0, 20, n);
      check("p4_first_half", n, 4);
      wait_toggle(0, 20, n);
      check("p4_second_half", n, 4);

      // retune 4 -> 10, then 10 -> 3 written at counter 2
      wr(0, 10, 15);
      wait_toggle(0, 20, n);
      wait_toggle(0, 20, n);
      check("p10_half", n, 10);
      tick();
      tick();
      wr(0, 3, 15);
      wait_toggle(0, 20, n);
      check("retune_old_half", n + 3, 10);
      wait_toggle(0, 20, n);
      check("retune_new_half1", n, 3);
      wait_toggle(0, 20, n);
      check("retune_new_half2", n, 3);

      // back-to-back writes on a running channel: last one wins
      oe[1] = 1'b1;
      wr(1, 100, 4);
      wait_toggle(1, 200, n);
      check("p100_half", n, 100);
      repeat (5) tick();
      wr(1, 20, 4);
      repeat (3) tick();
      wr(1, 50, 4);
      wait_toggle(1, 200, n);
      check("b2b_old_half", n + 10, 100);
      wait_toggle(1, 200, n);
      check("b2b_new_half", n, 50);

      // enable gating
      if (square_wave_out[0] !== 1'b1) wait_toggle(0, 20, n);
      tick();
      oe[0] = 1'b0;
      tick();
      check("gate_off", 32'(square_wave_out[0]), 0);
      tick();
      wr(0, half_period(12_500_000), 15);
      repeat (3) tick();
      oe[0] = 1'b1;
      wait_toggle(0, 20, n);
      check("reenable_first_toggle", n, 5);

      // mix PWM, vol 8 + 4 held high
      oe = '0;
      tick();
      tick();
      wr(0, 200, 8);
      wr(1, 200, 4);
      oe = 3'b011;
      wait_toggle(0, 250, n);
      check("mix_setup_toggle", n, 200);
      check("mix_ch1_high", 32'(square_wave_out[1]), 1);
      tick();
      cnt = 0;
      repeat (64) begin
         tick();
         cnt += int'(mix_out);
      end
      check("mix_duty_12_of_64", cnt, 12);

      // all volumes zero
      oe = '0;
      tick();
      tick();
      wr(0, 200, 0);
      wr(1, 200, 0);
      oe = 3'b011;
      cnt = 0;
      repeat (300) begin
         tick();
         cnt += int'(mix_out);
      end
      check("mix_zero_volume", cnt, 0);

      // edge cases on ch2: P=0, P=1, out-of-range channel
      oe = 3'b100;
      tick();
      tick();
      wr(2, 0, 5);
      cnt = 0;
      repeat (20) begin
         tick();
         cnt += int'(square_wave_out[2]);
      end
      check("p0_silent", cnt, 0);
      wr(2, half_period(62_500_000), 5);
      cnt = 0;
      repeat (10) begin
         prev = square_wave_out[2];
         tick();
         if (square_wave_out[2] !== prev) cnt++;
      end
      check("p1_toggles", cnt, 10);
      wr(3, 7, 9);
      cnt = 0;
      repeat (10) begin
         prev = square_wave_out[2];
         tick();
         if (square_wave_out[2] !== prev) cnt++;
      end
      check("bad_ch_no_effect", cnt, 10);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            int k;
            k = int'($urandom_range(0, NCH - 1));
            oe[k] = ~oe[k];
         end
         cfg_valid = ($urandom_range(0, 9) < 3);
         cfg_ch    = CH_W'($urandom_range(0, 3));
         cfg_hp    = ($urandom_range(0, 19) == 0) ? '0 : PERIOD_W'($urandom_range(1, 12));
         cfg_vol   = VOL_W'($urandom_range(0, 15));
         tick();
      end
      cfg_valid = 1'b0;

      // reset mid-tone
      oe = '0;
      tick();
      tick();
      wr(2, 1, 15);
      oe = 3'b100;
      tick();
      if (square_wave_out[2] !== 1'b1) tick();
      check("pre_reset_tone_high", 32'(square_wave_out[2]), 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_swo", 32'(square_wave_out), 0);
      check("async_reset_mix", 32'(mix_out), 0);
      check("async_reset_ready", 32'(cfg_ready), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
